// File: rtl/capsense_event_tx_pkg.sv
// Shared definitions for the CapSense event path: parameter defaults and event record layout.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
//
// Event record layout, MSB to LSB: { button index (IDX_W), press (1), timestamp (TS_W) }.
// The CapSense_Sys wrapper imports this package so both ends agree on the packing.
package capsense_event_tx_pkg;

    localparam int CS_N_DEFAULT          = 4;
    localparam int CS_DEB_DEFAULT        = 3;
    localparam int CS_FIFO_DEPTH_DEFAULT = 4;
    localparam int CS_TS_W_DEFAULT       = 16;

    // Button index width; a single button still needs a 1-bit field.
    function automatic int cs_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Total record width.
    function automatic int cs_ev_w(input int n, input int ts_w);
        return cs_idx_w(n) + 1 + ts_w;
    endfunction

    // Field offsets inside a record.
    function automatic int cs_ev_ts_lsb();
        return 0;
    endfunction

    function automatic int cs_ev_dir_bit(input int ts_w);
        return ts_w;
    endfunction

    function automatic int cs_ev_idx_lsb(input int ts_w);
        return ts_w + 1;
    endfunction

    // Debounce counter width: must hold values 0..DEB-1.
    function automatic int cs_cnt_w(input int deb);
        return (deb > 1) ? $clog2(deb) : 1;
    endfunction

endpackage

// File: rtl/capsense_ev_fifo.sv
// Synchronous show-ahead FIFO holding packed event records.
// Latency: a push is visible on rd_dat_o / empty_o the cycle after the push edge.
// Backpressure: push_i is ignored while full_o=1 (full is judged before any same-cycle pop).
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (empties the FIFO)
//   push_i, push_dat_i write one record
//   pop_i              drop the head record (ignored when empty)
//   rd_dat_o           head record, stable until popped
//   full_o, empty_o    occupancy flags
module capsense_ev_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o   = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says it is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/capsense_event_tx.sv
// Debounces CapSense button samples and streams press/release event records.
// Latency: strobe at T -> stable_o at T+1 -> record pushed at the T+1 edge -> ev_valid_o at T+2.
// Backpressure: with the FIFO full, commits wait in a per-button pending slot; a second commit
//               on a still-pending button overwrites it and sets the sticky overflow_o.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   sample_stb_i, sampled_i      one-cycle poll strobe and raw touch vector (1 = touched)
//   stable_o                     debounced button state
//   ev_valid_o, ev_ready_i       event stream handshake (pop on valid & ready)
//   ev_btn_o, ev_press_o, ev_ts_o event record: button, 1=press/0=release, strobe-count stamp
//   overflow_o, clr_ovf_i        sticky lost-transition flag and its clear (set wins)
module capsense_event_tx
    import capsense_event_tx_pkg::*;
#(
    parameter int N          = CS_N_DEFAULT,
    parameter int DEB        = CS_DEB_DEFAULT,
    parameter int FIFO_DEPTH = CS_FIFO_DEPTH_DEFAULT,
    parameter int TS_W       = CS_TS_W_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sample_stb_i,
    input  logic [N-1:0]           sampled_i,
    output logic [N-1:0]           stable_o,
    output logic                   ev_valid_o,
    input  logic                   ev_ready_i,
    output logic [cs_idx_w(N)-1:0] ev_btn_o,
    output logic                   ev_press_o,
    output logic [TS_W-1:0]        ev_ts_o,
    output logic                   overflow_o,
    input  logic                   clr_ovf_i
);

    localparam int IDX_W      = cs_idx_w(N);
    localparam int EV_W       = cs_ev_w(N, TS_W);
    localparam int CNT_W      = cs_cnt_w(DEB);
    localparam int EV_TS_LSB  = cs_ev_ts_lsb();
    localparam int EV_DIR_BIT = cs_ev_dir_bit(TS_W);
    localparam int EV_IDX_LSB = cs_ev_idx_lsb(TS_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);

    // Debounce state
    logic [N-1:0]            stable_q, stable_d;
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]            commit;

    // Timestamp
    logic [TS_W-1:0]         ts_q, ts_d;

    // Pending (committed but not yet queued) events, one slot per button
    logic [N-1:0]            pend_q, pend_d;
    logic [N-1:0]            pdir_q, pdir_d;
    logic [N-1:0][TS_W-1:0]  pts_q, pts_d;

    // Overflow flag
    logic                    ovf_q, ovf_d;
    logic                    ovf_set;

    // Scanner
    logic                    sel_vld;
    logic [IDX_W-1:0]        sel_idx;
    logic                    push;
    logic [N-1:0]            push_mask;
    logic [EV_W-1:0]         push_dat;

    // FIFO side
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [EV_W-1:0]         fifo_rd_dat;
    logic                    pop;

    // ------------------------------------------------------------------
    // Debounce: a change commits after DEB consecutive differing samples.
    // Any sample that matches the stable state restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        commit   = '0;
        if (sample_stb_i) begin
            for (int i = 0; i < N; i++) begin
                if (sampled_i[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    commit[i]   = 1'b1;
                    stable_d[i] = sampled_i[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Commits record the pre-increment strobe count.
    assign ts_d = ts_q + TS_W'(sample_stb_i);

    // ------------------------------------------------------------------
    // Scanner: lowest-index pending button wins; at most one push per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        // Walk downward so the last hit, i.e. the lowest index, is kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign push = sel_vld & ~fifo_full;

    always_comb begin
        push_mask = '0;
        if (push) begin
            push_mask[sel_idx] = 1'b1;
        end
    end

    // The pushed record always carries the registered slot contents, so a commit
    // landing on the same button in the same cycle stays pending with its new values.
    assign push_dat = {sel_idx, pdir_q[sel_idx], pts_q[sel_idx]};

    always_comb begin
        pend_d = (pend_q & ~push_mask) | commit;
        pdir_d = pdir_q;
        pts_d  = pts_q;
        for (int i = 0; i < N; i++) begin
            if (commit[i]) begin
                pdir_d[i] = sampled_i[i];
                pts_d[i]  = ts_q;
            end
        end
    end

    // A transition is lost only if the slot still holds an event that is not
    // leaving for the FIFO this cycle.
    assign ovf_set = |(commit & pend_q & ~push_mask);
    assign ovf_d   = ovf_set | (ovf_q & ~clr_ovf_i);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_q <= '0;
            cnt_q    <= '0;
            ts_q     <= '0;
            pend_q   <= '0;
            pdir_q   <= '0;
            pts_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            ts_q     <= ts_d;
            pend_q   <= pend_d;
            pdir_q   <= pdir_d;
            pts_q    <= pts_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO and output unpacking
    // ------------------------------------------------------------------
    assign pop = ev_valid_o & ev_ready_i;

    capsense_ev_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .rd_dat_o   (fifo_rd_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign ev_valid_o = ~fifo_empty;
    assign ev_btn_o   = fifo_rd_dat[EV_W-1:EV_IDX_LSB];
    assign ev_press_o = fifo_rd_dat[EV_DIR_BIT];
    assign ev_ts_o    = fifo_rd_dat[EV_DIR_BIT-1:EV_TS_LSB];
    assign stable_o   = stable_q;
    assign overflow_o = ovf_q;

endmodule
